// File: rtl/ldl_cdc_ring_pkg.sv
// ---------------------------------------------------------------------------
// ldl_cdc_ring_pkg
// Shared definitions for both ends of the CDC ring.
//   RING_AW  : default log2 ring depth
//   DEPTH    : number of ring slots (1 << RING_AW), shared with the writer
//   bin2gray : binary -> Gray conversion
//   gray2bin : Gray -> binary conversion for a pointer of width w
// Both conversions work on a zero-extended 32-bit value, so any pointer
// width up to 32 bits can use them; callers cast the result back down.
// ---------------------------------------------------------------------------
package ldl_cdc_ring_pkg;

  localparam int RING_AW = 2;
  localparam int DEPTH   = 1 << RING_AW;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Bits above w are assumed zero on entry; they are masked off on exit so
  // a caller that passes a wider value still gets a clean w-bit result.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray,
                                           input int          w);
    logic [31:0] bin;
    logic [31:0] mask;
    bin     = '0;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return bin & mask;
  endfunction

endpackage

// File: rtl/ldl_sync_bus.sv
// ---------------------------------------------------------------------------
// ldl_sync_bus
// Multi-flop synchroniser for a bus that changes at most one bit per source
// update (a Gray-coded pointer). Pure flop chain, no logic between stages.
// Parameters:
//   W      bus width
//   LEVEL  number of flop stages (2 or more)
// Ports:
//   clk  destination-domain clock
//   rst  asynchronous active-high reset, clears every stage
//   d    bus from the foreign clock domain
//   q    synchronised bus (output of the last stage)
// ---------------------------------------------------------------------------
module ldl_sync_bus #(
  parameter int W     = 1,
  parameter int LEVEL = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // chain[0] is the metastability-catching stage, chain[LEVEL-1] the output.
  logic [LEVEL-1:0][W-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[LEVEL-2:0], d};
    end
  end

  assign q = chain[LEVEL-1];

endmodule

// File: rtl/ldl_cdc_ring_rd.sv
// ---------------------------------------------------------------------------
// ldl_cdc_ring_rd
// Read end of the CDC ring, entirely in the receive clock domain.
// Synchronises the writer's Gray pointer, pops ring slots in order into a
// single output register (valid/ready stream) and returns its own Gray read
// pointer to the writer straight from a flop.
// Parameters:
//   WIDTH  slot data width
//   AW     log2 ring depth; pointers carry one extra wrap bit (AW+1 bits)
//   LEVEL  synchroniser stages on wr_ptr_gray (2 or more)
// Ports:
//   clk          receive-domain clock
//   rst          asynchronous active-high reset
//   wr_ptr_gray  writer pointer, Gray code, asynchronous to clk
//   rd_addr      slot index presented to ring storage
//   rd_data      slot contents at rd_addr
//   rd_ptr_gray  registered read pointer, Gray code, back to the writer
//   dout         output word
//   dout_vld     dout holds a word
//   dout_rdy     consumer takes dout this cycle
//   level        registered ring occupancy seen by the reader
//   ovf          sticky: occupancy went beyond the ring depth
// ---------------------------------------------------------------------------
module ldl_cdc_ring_rd
  import ldl_cdc_ring_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = RING_AW,
  parameter int LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW:0]      wr_ptr_gray,
  output logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      rd_ptr_gray,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic [AW:0]      level,
  output logic             ovf
);

  localparam int           PW    = AW + 1;
  localparam logic [AW:0]  SLOTS = PW'(1 << AW);

  logic [AW:0] wsync_gray;
  logic [AW:0] wsync_bin;
  logic [AW:0] rd_ptr_bin;
  logic [AW:0] rd_ptr_nxt;
  logic [AW:0] occ;
  logic        empty;
  logic        bad_occ;
  logic        pop;

  // Stage 0: bring the writer pointer into this domain.
  ldl_sync_bus #(
    .W     (PW),
    .LEVEL (LEVEL)
  ) u_wsync (
    .clk (clk),
    .rst (rst),
    .d   (wr_ptr_gray),
    .q   (wsync_gray)
  );

  // Pointer arithmetic on pre-edge values. The modulo-2^(AW+1) subtraction
  // falls out of the fixed pointer width.
  assign wsync_bin  = PW'(gray2bin(32'(wsync_gray), PW));
  assign occ        = wsync_bin - rd_ptr_bin;
  assign empty      = (occ == '0);
  assign bad_occ    = (occ > SLOTS);
  assign rd_ptr_nxt = rd_ptr_bin + 1'b1;
  assign rd_addr    = rd_ptr_bin[AW-1:0];

  // An impossible occupancy means the slot under rd_addr cannot be trusted,
  // so it blocks popping on the very edge it is detected as well as after.
  assign pop = !empty && !bad_occ && !ovf && (!dout_vld || dout_rdy);

  // Stage 1: output register, read pointer, occupancy and overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_bin  <= '0;
      rd_ptr_gray <= '0;
      dout        <= '0;
      dout_vld    <= 1'b0;
      level       <= '0;
      ovf         <= 1'b0;
    end else begin
      level <= occ;
      if (bad_occ) begin
        ovf <= 1'b1;
      end
      if (pop) begin
        dout        <= rd_data;
        dout_vld    <= 1'b1;
        rd_ptr_bin  <= rd_ptr_nxt;
        rd_ptr_gray <= PW'(bin2gray(32'(rd_ptr_nxt)));
      end else if (ovf || bad_occ) begin
        dout_vld <= 1'b0;
      end else if (dout_rdy) begin
        // Word consumed with nothing behind it; dout keeps its last value.
        dout_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ldl_cdc_ring_rd.sv
module tb_ldl_cdc_ring_rd;

  localparam int WIDTH = 8;
  localparam int AW    = 2;
  localparam int LEVEL = 2;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic             clk = 1'b0;
  logic             rst;
  logic [PW-1:0]    wr_ptr_gray;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [PW-1:0]    rd_ptr_gray;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic             dout_rdy;
  logic [PW-1:0]    level;
  logic             ovf;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_bin;
  logic [WIDTH-1:0] sbq [$];
  int               checks = 0;
  int               errors = 0;
  int               n_acc  = 0;

  always #5 clk = ~clk;

  assign rd_data = mem[rd_addr];

  ldl_cdc_ring_rd #(
    .WIDTH (WIDTH),
    .AW    (AW),
    .LEVEL (LEVEL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_ptr_gray (rd_ptr_gray),
    .dout        (dout),
    .dout_vld    (dout_vld),
    .dout_rdy    (dout_rdy),
    .level       (level),
    .ovf         (ovf)
  );

  function automatic logic [PW-1:0] g_of(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] b_of(input logic [PW-1:0] g);
    logic [PW-1:0] r;
    r[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) r[i] = r[i+1] ^ g[i];
    return r;
  endfunction

  function automatic logic ring_full();
    logic [PW-1:0] occ;
    occ = wr_bin - b_of(rd_ptr_gray);
    return (occ >= PW'(DEPTH));
  endfunction

  // Writer model: fill the slot, advance the pointer, expect the word.
  task automatic push_word(input logic [WIDTH-1:0] d);
    mem[wr_bin[AW-1:0]] = d;
    sbq.push_back(d);
    wr_bin      = wr_bin + 1'b1;
    wr_ptr_gray = g_of(wr_bin);
  endtask

  // One clock: handshake sampled on the falling edge, then step past the
  // rising edge so callers drive and observe #1 after it.
  task automatic cycle();
    logic [WIDTH-1:0] exp;
    @(negedge clk);
    if (dout_vld && dout_rdy) begin
      checks++;
      n_acc++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: dout=%h accepted, expected nothing", dout);
      end else begin
        exp = sbq.pop_front();
        if (dout !== exp) begin
          errors++;
          $display("FAIL sb_data: dout=%h expected %h", dout, exp);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    wr_bin      = '0;
    wr_ptr_gray = '0;
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    wr_ptr_gray = 3'd5;
    wr_bin      = '0;
    dout_rdy    = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr: got %h expected 0", rd_addr); end
    checks++; if (rd_ptr_gray !== '0) begin errors++; $display("FAIL reset_rd_ptr_gray: got %h expected 0", rd_ptr_gray); end
    checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout: got %h expected 0", dout); end
    checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL reset_dout_vld: got %b expected 0", dout_vld); end
    checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %h expected 0", level); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    wr_ptr_gray = '0;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (dout_vld !== 1'b0) begin errors++; $display("FAIL release_dout_vld: got %b expected 0 at cycle %0d", dout_vld, i); end
    end
  endtask

  task automatic test_basic();
    int lat, first, last, nvld;
    logic [WIDTH-1:0] words [3];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    dout_rdy = 1'b1;
    lat = -1; first = -1; last = -1; nvld = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc < 3) push_word(words[cyc]);
      cycle();
      if (dout_vld) begin
        if (first < 0) begin first = cyc; lat = cyc + 1; end
        last = cyc;
        nvld++;
      end
    end
    checks++; if (lat != LEVEL + 1) begin errors++; $display("FAIL basic_latency: got %0d edges expected %0d", lat, LEVEL + 1); end
    checks++; if (nvld != 3 || last - first != 2) begin errors++; $display("FAIL basic_back_to_back: got %0d valid over span %0d expected 3 over 2", nvld, last - first); end
    checks++; if (rd_ptr_gray !== 3'd2) begin errors++; $display("FAIL basic_rd_ptr_gray: got %h expected 2", rd_ptr_gray); end
    checks++; if (sbq.size() != 0) begin errors++; $display("FAIL basic_drained: got %0d words left expected 0", sbq.size()); end
  endtask

  task automatic test_full();
    logic [PW-1:0] start_rd;
    int peak, guard;
    dout_rdy = 1'b0;
    start_rd = b_of(rd_ptr_gray);
    for (int i = 0; i < DEPTH; i++) push_word(8'hA0 + 8'(i));
    peak = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (int'(level) > peak) peak = int'(level);
    end
    checks++; if (peak != DEPTH) begin errors++; $display("FAIL full_level: got peak %0d expected %0d", peak, DEPTH); end
    checks++; if (dout_vld !== 1'b1 || dout !== 8'hA0) begin errors++; $display("FAIL full_latched: got vld=%b dout=%h expected vld=1 dout=a0", dout_vld, dout); end
    checks++; if (rd_ptr_gray !== g_of(start_rd + 1'b1)) begin errors++; $display("FAIL full_ptr_frozen: got %h expected %h", rd_ptr_gray, g_of(start_rd + 1'b1)); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL full_no_ovf: got %b expected 0", ovf); end
    dout_rdy = 1'b1;
    guard = 0;
    while (sbq.size() != 0 && guard < 20) begin
      cycle();
      guard++;
    end
    checks++; if (sbq.size() != 0) begin errors++; $display("FAIL full_drain_timeout: got %0d words left expected 0", sbq.size()); end
    repeat (2) cycle();
    checks++; if (dout_vld !== 1'b0 || level !== '0) begin errors++; $display("FAIL full_drained: got vld=%b level=%0d expected 0 0", dout_vld, level); end
  endtask

  task automatic test_wrap();
    int next, wraps, acc0, cyc;
    logic [PW-1:0] prev;
    next  = 0;
    wraps = 0;
    acc0  = n_acc;
    cyc   = 0;
    prev  = rd_ptr_gray;
    while ((next < 20 || sbq.size() != 0) && cyc < 600) begin
      if (next < 20 && !ring_full()) begin
        push_word(8'(next));
        next++;
      end
      dout_rdy = cyc[0];
      cycle();
      if (prev == g_of(3'd7) && rd_ptr_gray == 3'd0) wraps++;
      prev = rd_ptr_gray;
      cyc++;
    end
    checks++; if (next != 20 || sbq.size() != 0) begin errors++; $display("FAIL wrap_timeout: got %0d sent %0d left expected 20 sent 0 left", next, sbq.size()); end
    checks++; if (n_acc - acc0 != 20) begin errors++; $display("FAIL wrap_count: got %0d accepted expected 20", n_acc - acc0); end
    checks++; if (wraps < 1) begin errors++; $display("FAIL wrap_pointer: got %0d wraps expected at least 1", wraps); end
    dout_rdy = 1'b1;
    repeat (2) cycle();
  endtask

  task automatic test_ovf();
    int lat;
    logic saw_vld;
    do_reset();
    dout_rdy    = 1'b1;
    wr_ptr_gray = g_of(3'd5);
    lat = -1;
    saw_vld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (dout_vld) saw_vld = 1'b1;
      if (lat < 0 && ovf) lat = i + 1;
    end
    checks++; if (lat < LEVEL || lat > LEVEL + 1) begin errors++; $display("FAIL ovf_set: got latency %0d expected %0d..%0d", lat, LEVEL, LEVEL + 1); end
    checks++; if (saw_vld) begin errors++; $display("FAIL ovf_dout_vld: got vld=1 expected 0"); end
    wr_ptr_gray = '0;
    repeat (5) begin
      cycle();
      if (dout_vld) saw_vld = 1'b1;
    end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
    checks++; if (saw_vld || rd_ptr_gray !== '0) begin errors++; $display("FAIL ovf_no_pop: got vld=%b rd_ptr_gray=%h expected 0 0", saw_vld, rd_ptr_gray); end
    do_reset();
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %b expected 0", ovf); end
  endtask

  task automatic test_reset_midstream();
    int guard;
    dout_rdy = 1'b0;
    push_word(8'h5A);
    push_word(8'h6B);
    push_word(8'h7C);
    guard = 0;
    while (!dout_vld && guard < 8) begin
      cycle();
      guard++;
    end
    repeat (2) cycle();
    checks++; if (dout_vld !== 1'b1 || level !== 3'd2) begin errors++; $display("FAIL mid_pending: got vld=%b level=%0d expected 1 2", dout_vld, level); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL mid_async_clear: got vld=%b expected 0", dout_vld); end
    wr_bin      = '0;
    wr_ptr_gray = '0;
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) cycle();
    checks++; if (level !== '0 || rd_ptr_gray !== '0 || dout_vld !== 1'b0) begin errors++; $display("FAIL mid_release: got level=%0d rd_ptr_gray=%h vld=%b expected 0 0 0", level, rd_ptr_gray, dout_vld); end
  endtask

  initial begin
    rst         = 1'b1;
    wr_ptr_gray = '0;
    wr_bin      = '0;
    dout_rdy    = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_ovf();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
